// File: rtl/vme_init_pkg.sv
// ----------------------------------------------------------------------------
// vme_init_pkg
// Shared types for the VME register-access initiator: FSM state encoding,
// response status codes and a small helper that maps an acknowledge to a
// status code.
// Optional feature macro used by the bundle: VME_INIT_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package vme_init_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK      = 2'b00;
    localparam status_t ST_BUSERR  = 2'b01;
    localparam status_t ST_TIMEOUT = 2'b10;

    // An error acknowledge dominates a simultaneous done.
    function automatic status_t ack_status(input logic err);
        return err ? ST_BUSERR : ST_OK;
    endfunction

endpackage

// File: rtl/vme_reg_initiator_if.sv
// ----------------------------------------------------------------------------
// vme_reg_initiator_if
// Bundles the command port, response port and VME register bus of the
// initiator.
//   master : the initiator's view (drives cmd_ready, rsp_*, VMEAddr,
//            VMEWrData, VMERdMem, VMEWrMem)
//   slave  : the environment's view (command source, response sink and
//            register-bank responder)
// ----------------------------------------------------------------------------
interface vme_reg_initiator_if
    import vme_init_pkg::*;
#(
    parameter int ADDR_W = 18
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    status_t           rsp_status;

    logic [ADDR_W-1:0] VMEAddr;
    logic [31:0]       VMEWrData;
    logic              VMERdMem;
    logic              VMEWrMem;
    logic [31:0]       VMERdData;
    logic              VMERdDone;
    logic              VMEWrDone;
    logic              VMERdError;
    logic              VMEWrError;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        input  VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        output VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );

endinterface

// File: rtl/vme_init_timeout.sv
// ----------------------------------------------------------------------------
// vme_init_timeout
// Wait counter for the initiator. Only instantiated when VME_INIT_TIMEOUT_EN
// is defined.
// Ports:
//   Clk, Rst : clock, synchronous active-high reset
//   clr      : force the count to zero (transaction accepted)
//   en       : count this cycle (STROBE/WAIT)
//   expired  : count has reached TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module vme_init_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] count;

    // Saturates at the limit so expired stays asserted until the next clear.
    always_ff @(posedge Clk) begin
        if (Rst || clr) begin
            count <= 16'd0;
        end else if (en && (count != LIMIT)) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/vme_reg_initiator.sv
// ----------------------------------------------------------------------------
// vme_reg_initiator
// Single-outstanding initiator for the internal VME register-access bus.
// Accepts one read/write command, issues a one-cycle VMERdMem/VMEWrMem strobe
// with address/data held, waits for the matching Done/Error and returns read
// data plus a status code on the response port. All outputs are registered.
// Ports:
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : vme_reg_initiator_if.master (command, response, VME bus)
// Parameters:
//   ADDR_W         : word-address width (VMEAddr carries bits [ADDR_W+1:2])
//   TIMEOUT_CYCLES : wait limit from strobe, legal 2..65535
// Optional feature: define VME_INIT_TIMEOUT_EN to enable the wait timeout;
// without it WAIT is indefinite and status TIMEOUT is never produced.
// ----------------------------------------------------------------------------
module vme_reg_initiator
    import vme_init_pkg::*;
#(
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               Clk,
    input  logic               Rst,
    vme_reg_initiator_if.master bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("vme_reg_initiator: TIMEOUT_CYCLES must be in 2..65535");
    end

    state_t            state;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    status_t           rsp_status_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              rd_mem_q;
    logic              wr_mem_q;
    logic              we_q;

    logic accept;
    logic ack_done;
    logic ack_err;
    logic expired;

    assign accept = (state == IDLE) && cmd_ready_q && bus.cmd_valid;

    // Only the acknowledge pair matching the current direction is observed.
    assign ack_done = we_q ? bus.VMEWrDone  : bus.VMERdDone;
    assign ack_err  = we_q ? bus.VMEWrError : bus.VMERdError;

`ifdef VME_INIT_TIMEOUT_EN
    vme_init_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .Clk    (Clk),
        .Rst    (Rst),
        .clr    (accept),
        .en     ((state == STROBE) || (state == WAIT)),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_status_q <= ST_OK;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            rd_mem_q     <= 1'b0;
            wr_mem_q     <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q        <= bus.cmd_we;
                        addr_q      <= bus.cmd_addr;
                        wdata_q     <= bus.cmd_wdata;
                        rd_mem_q    <= ~bus.cmd_we;
                        wr_mem_q    <= bus.cmd_we;
                        cmd_ready_q <= 1'b0;
                        state       <= STROBE;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                // An acknowledge during the strobe cycle is treated as in WAIT.
                STROBE, WAIT: begin
                    rd_mem_q <= 1'b0;
                    wr_mem_q <= 1'b0;
                    if (ack_done || ack_err) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ack_status(ack_err);
                        rsp_rdata_q  <= (ack_err || we_q) ? 32'd0 : bus.VMERdData;
                        state        <= RESP;
                    end else if (expired) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= ST_TIMEOUT;
                        rsp_rdata_q  <= 32'd0;
                        state        <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.VMEAddr    = addr_q;
    assign bus.VMEWrData  = wdata_q;
    assign bus.VMERdMem   = rd_mem_q;
    assign bus.VMEWrMem   = wr_mem_q;

endmodule

// File: tb/tb_vme_reg_initiator.sv
// ----------------------------------------------------------------------------
// tb_vme_reg_initiator
// Table of read/write transactions with a behavioural responder, expected
// responses queued on command issue and compared on rsp_valid, plus
// hand-written reset and timeout sequences.
// Honours VME_INIT_TIMEOUT_EN (TIMEOUT_CYCLES is set to 16).
// ----------------------------------------------------------------------------
module tb_vme_reg_initiator;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    always #5 Clk = ~Clk;

    vme_reg_initiator_if #(.ADDR_W(18)) bus ();

    vme_reg_initiator #(
        .ADDR_W        (18),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    typedef struct {
        logic        we;
        logic [17:0] addr;
        logic [31:0] wdata;
        int          lat;      // ack cycle offset after strobe, -1 = never
        logic        done;
        logic        err;
        logic        stray;    // opposite-direction done/error in cycle 2
        logic [31:0] rd_val;
        int          hold;     // cycles rsp_ready held low in RESP
        logic [31:0] exp_rdata;
        logic [1:0]  exp_status;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  status;
        int          cyc;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_resp(input logic rd_done, input logic rd_err, input logic wr_done,
                              input logic wr_err, input logic [31:0] rdata);
        bus.VMERdDone  = rd_done;
        bus.VMERdError = rd_err;
        bus.VMEWrDone  = wr_done;
        bus.VMEWrError = wr_err;
        bus.VMERdData  = rdata;
    endtask

    task automatic run_txn(input int id, input vec_t v);
        exp_t  e;
        bit    got;
        string p;
        p = $sformatf("v%0d", id);
        @(negedge Clk);
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge Clk);
        chk({p, "_cmd_ready_c0"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = v.we;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        drive_resp(1'b0, 1'b0, 1'b0, 1'b0, ~v.rd_val);
        sb.push_back('{v.exp_rdata, v.exp_status, v.exp_cyc});
        got = 1'b0;
        for (int cyc = 1; cyc <= 80 && !got; cyc++) begin
            @(negedge Clk);
            bus.cmd_valid = 1'b0;
            if (cyc == 1) begin
                chk({p, "_rdmem_c1"}, 32'(bus.VMERdMem), 32'(!v.we));
                chk({p, "_wrmem_c1"}, 32'(bus.VMEWrMem), 32'(v.we));
                chk({p, "_addr_c1"}, 32'(bus.VMEAddr), 32'(v.addr));
            end
            if (cyc == 2) begin
                chk({p, "_strobes_c2"}, 32'({bus.VMERdMem, bus.VMEWrMem}), 32'd0);
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk({p, "_sb_empty"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({p, "_rsp_cycle"}, 32'(cyc), 32'(e.cyc));
                    chk({p, "_rdata"}, bus.rsp_rdata, e.rdata);
                    chk({p, "_status"}, 32'(bus.rsp_status), 32'(e.status));
                end
                chk({p, "_addr_resp"}, 32'(bus.VMEAddr), 32'(v.addr));
                chk({p, "_wdata_resp"}, bus.VMEWrData, v.wdata);
                drive_resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
                for (int h = 0; h < v.hold; h++) begin
                    // Late acknowledges and a competing command must change nothing.
                    bus.cmd_valid = 1'b1;
                    bus.cmd_we    = ~v.we;
                    bus.cmd_addr  = ~v.addr;
                    drive_resp(1'b1, 1'b1, 1'b1, 1'b1, 32'h5555AAAA);
                    bus.rsp_ready = 1'b0;
                    @(negedge Clk);
                    chk({p, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
                    chk({p, "_hold_rdata"}, bus.rsp_rdata, v.exp_rdata);
                    chk({p, "_hold_status"}, 32'(bus.rsp_status), 32'(v.exp_status));
                    chk({p, "_hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
                    chk({p, "_hold_strobes"}, 32'({bus.VMERdMem, bus.VMEWrMem}), 32'd0);
                end
                bus.rsp_ready = 1'b1;
                @(negedge Clk);
                bus.rsp_ready = 1'b0;
                bus.cmd_valid = 1'b0;
                drive_resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
                chk({p, "_post_valid"}, 32'(bus.rsp_valid), 32'd0);
                chk({p, "_post_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
                got = 1'b1;
            end else begin
                if (v.lat >= 0 && cyc == 1 + v.lat) begin
                    if (v.we) drive_resp(1'b0, 1'b0, v.done, v.err, ~v.rd_val);
                    else      drive_resp(v.done, v.err, 1'b0, 1'b0, v.rd_val);
                end else begin
                    drive_resp(1'b0, 1'b0, 1'b0, 1'b0, ~v.rd_val);
                end
                if (v.stray && cyc == 2) begin
                    if (v.we) begin
                        bus.VMERdDone  = 1'b1;
                        bus.VMERdError = 1'b1;
                    end else begin
                        bus.VMEWrDone  = 1'b1;
                        bus.VMEWrError = 1'b1;
                    end
                end
            end
        end
        if (!got) begin
            chk({p, "_rsp_wait_budget"}, 32'd0, 32'd1);
            void'(sb.pop_back());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   we  addr      wdata         lat done err stray rd_val        hold exp_rdata     st     cyc
        vecs.push_back('{1'b0, 18'h00001, 32'h0,        1, 1'b1, 1'b0, 1'b0, 32'h0000ABCD, 0, 32'h0000ABCD, 2'b00, 3});
        vecs.push_back('{1'b1, 18'h00002, 32'hDEADBEEF, 2, 1'b1, 1'b0, 1'b0, 32'h0,        0, 32'h0,        2'b00, 4});
        vecs.push_back('{1'b0, 18'h00003, 32'h0,        1, 1'b1, 1'b1, 1'b1, 32'h11112222, 0, 32'h0,        2'b01, 3});
        vecs.push_back('{1'b1, 18'h00004, 32'hCAFEF00D, 2, 1'b0, 1'b1, 1'b0, 32'h0,        0, 32'h0,        2'b01, 4});
        vecs.push_back('{1'b0, 18'h00005, 32'h0,        0, 1'b1, 1'b0, 1'b0, 32'h0BADF00D, 0, 32'h0BADF00D, 2'b00, 2});
        vecs.push_back('{1'b0, 18'h2AAAA, 32'h0,        4, 1'b1, 1'b0, 1'b0, 32'h12345678, 5, 32'h12345678, 2'b00, 6});
        vecs.push_back('{1'b1, 18'h00007, 32'h13579BDF, 3, 1'b1, 1'b0, 1'b1, 32'h0,        0, 32'h0,        2'b00, 5});
        vecs.push_back('{1'b0, 18'h3FFFF, 32'h0,        1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 2'b00, 3});
        vecs.push_back('{1'b0, 18'h00009, 32'h0,       16, 1'b1, 1'b0, 1'b0, 32'h00C0FFEE, 0, 32'h00C0FFEE, 2'b00, 18});
        vecs.push_back('{1'b1, 18'h0000A, 32'hA5A5A5A5, 2, 1'b1, 1'b0, 1'b0, 32'h0,        5, 32'h0,        2'b00, 4});
`ifdef VME_INIT_TIMEOUT_EN
        vecs.push_back('{1'b0, 18'h0000B, 32'h0,       -1, 1'b0, 1'b0, 1'b0, 32'h77777777, 3, 32'h0,        2'b10, 18});
`else
        vecs.push_back('{1'b0, 18'h0000B, 32'h0,       40, 1'b1, 1'b0, 1'b0, 32'h0000BEEF, 0, 32'h0000BEEF, 2'b00, 42});
`endif

        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        drive_resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Reset state, during and on the first cycle after reset.
        repeat (3) @(negedge Clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_strobes", 32'({bus.VMERdMem, bus.VMEWrMem}), 32'd0);
        chk("rst_addr", 32'(bus.VMEAddr), 32'd0);
        chk("rst_wdata", bus.VMEWrData, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_status", 32'(bus.rsp_status), 32'd0);
        Rst = 1'b0;
        #1;
        chk("rst_first_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge Clk);
        chk("rst_cmd_ready_rises", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_txn(i, vecs[i]);

        // Reset pulse during WAIT aborts the read.
        @(negedge Clk);
        chk("rw_cmd_ready_c0", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 18'h00100;
        @(negedge Clk);
        bus.cmd_valid = 1'b0;
        chk("rw_rdmem_c1", 32'(bus.VMERdMem), 32'd1);
        @(negedge Clk);
        chk("rw_wait_valid", 32'(bus.rsp_valid), 32'd0);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("rw_strobes", 32'({bus.VMERdMem, bus.VMEWrMem}), 32'd0);
        chk("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rw_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        drive_resp(1'b1, 1'b0, 1'b0, 1'b0, 32'h99999999);
        @(negedge Clk);
        drive_resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rw_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
        chk("rw_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge Clk);
        chk("rw_no_rsp2", 32'(bus.rsp_valid), 32'd0);
        chk("rw_sb_empty", 32'(sb.size()), 32'd0);
        run_txn(99, '{1'b0, 18'h00101, 32'h0, 1, 1'b1, 1'b0, 1'b0, 32'h600DCAFE, 0,
                      32'h600DCAFE, 2'b00, 3});

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
